// File: rtl/wave_cmd_ctrl.sv
// UART command decoder for the waveform datapath: stages changes in shadow registers, commits at I2S frame start.
// Latency: byte to cmd_err 1 cycle, byte to active outputs <= 1 frame; no backpressure, every rx byte is consumed.
module wave_cmd_ctrl #(
  parameter int unsigned ARG_TIMEOUT = 250000,
  parameter logic [3:0]  FREQ_RESET  = 4'd0,
  parameter bit          FRAME_SYNC  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       frame_strobe_i,
  output logic [1:0] wave_sel_o,
  output logic       noise_en_o,
  output logic [3:0] freq_idx_o,
  output logic       cfg_update_o,
  output logic       cmd_err_o,
  output logic [7:0] err_count_o,
  output logic       busy_o
);

  localparam int unsigned TW = $clog2(ARG_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ARG_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_ARG} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    sh_wave_q, sh_wave_d;
  logic          sh_noise_q, sh_noise_d;
  logic [3:0]    sh_freq_q, sh_freq_d;
  logic          pending_q, pending_d;
  logic          set_pend;
  logic          commit;
  logic [1:0]    wave_q;
  logic          noise_q;
  logic [3:0]    freq_q;
  logic          cfg_q;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    sh_wave_d  = sh_wave_q;
    sh_noise_d = sh_noise_q;
    sh_freq_d  = sh_freq_q;
    set_pend   = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          case (rx_data_i)
            8'h57: begin sh_wave_d = 2'b00; set_pend = 1'b1; end
            8'h51: begin sh_wave_d = 2'b01; set_pend = 1'b1; end
            8'h54: begin sh_wave_d = 2'b10; set_pend = 1'b1; end
            8'h53: begin sh_wave_d = 2'b11; set_pend = 1'b1; end
            8'h4E: begin sh_noise_d = 1'b1; set_pend = 1'b1; end
            8'h46: begin sh_noise_d = 1'b0; set_pend = 1'b1; end
            8'h41: begin state_d = WAIT_ARG; timer_d = '0; end
            8'h0D, 8'h0A: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      WAIT_ARG: begin
        timer_d = timer_q + TW'(1);
        // A byte arriving on the timeout cycle wins over the timeout.
        if (rx_valid_i) begin
          state_d = IDLE;
          if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
            sh_freq_d = rx_data_i[3:0];
            set_pend  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Commit copies the shadow values from before this cycle's byte.
    commit    = FRAME_SYNC ? (frame_strobe_i && pending_q) : pending_q;
    pending_d = set_pend || (pending_q && !commit);
    busy_d    = (state_d == WAIT_ARG) || pending_d;
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      sh_wave_q  <= 2'b00;
      sh_noise_q <= 1'b0;
      sh_freq_q  <= FREQ_RESET;
      pending_q  <= 1'b0;
      wave_q     <= 2'b00;
      noise_q    <= 1'b0;
      freq_q     <= FREQ_RESET;
      cfg_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sh_wave_q  <= sh_wave_d;
      sh_noise_q <= sh_noise_d;
      sh_freq_q  <= sh_freq_d;
      pending_q  <= pending_d;
      cfg_q      <= commit;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
      if (commit) begin
        wave_q  <= sh_wave_q;
        noise_q <= sh_noise_q;
        freq_q  <= sh_freq_q;
      end
    end
  end

  assign wave_sel_o   = wave_q;
  assign noise_en_o   = noise_q;
  assign freq_idx_o   = freq_q;
  assign cfg_update_o = cfg_q;
  assign cmd_err_o    = err_q;
  assign err_count_o  = err_cnt_q;
  assign busy_o       = busy_q;

endmodule
